// File: rtl/rectangle128_pkg.sv
// Shared constants, FSM state type and subkey helpers for the RECTANGLE-128 key schedule.
package rectangle128_pkg;

    localparam int unsigned NUM_SKEYS = 26;
    localparam logic [4:0]  RC_INIT   = 5'h01;
    localparam logic [4:0]  LAST_IDX  = 5'(NUM_SKEYS - 1);

    localparam logic [3:0] SBOX [16] = '{
        4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
        4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_GEN   = 2'd2,
        ST_DONE  = 2'd3
    } ks_state_t;

    // Low halfword of every row, Row3 in the top bits.
    function automatic logic [63:0] skey_extract(input logic [127:0] st);
        return {st[111:96], st[79:64], st[47:32], st[15:0]};
    endfunction

    function automatic logic [4:0] rc_next(input logic [4:0] rc);
        return {rc[3:0], rc[4] ^ rc[2]};
    endfunction

endpackage

// File: rtl/rectangle128_ks_round.sv
// One combinational RECTANGLE-128 key-update round: column S-box on the low
// byte of each row, then the row Feistel/rotation step and round-constant XOR.
module rectangle128_ks_round
    import rectangle128_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [4:0]   rc_i,
    output logic [127:0] state_o
);

    logic [127:0] sub_s;
    logic [3:0]   col_s;
    logic [3:0]   sbx_s;
    logic [31:0]  r0_s;
    logic [31:0]  r1_s;
    logic [31:0]  r2_s;
    logic [31:0]  r3_s;
    logic [31:0]  n0_s;
    logic [31:0]  n2_s;

    // Substitute columns 0..7; each column nibble takes Row0 as its LSB.
    always_comb begin
        sub_s = state_i;
        col_s = 4'h0;
        sbx_s = 4'h0;
        for (int j = 0; j < 8; j++) begin
            col_s = {state_i[96 + j], state_i[64 + j], state_i[32 + j], state_i[j]};
            sbx_s = SBOX[col_s];
            sub_s[j]      = sbx_s[0];
            sub_s[32 + j] = sbx_s[1];
            sub_s[64 + j] = sbx_s[2];
            sub_s[96 + j] = sbx_s[3];
        end
    end

    assign r0_s = sub_s[31:0];
    assign r1_s = sub_s[63:32];
    assign r2_s = sub_s[95:64];
    assign r3_s = sub_s[127:96];

    assign n0_s = {r0_s[23:0], r0_s[31:24]} ^ r1_s ^ {27'd0, rc_i};
    assign n2_s = {r2_s[15:0], r2_s[31:16]} ^ r3_s;

    assign state_o = {r0_s, n2_s, r2_s, n0_s};

endmodule

// File: rtl/rectangle128_keysched_ctrl.sv
// RECTANGLE-128 key-schedule sequencer: clears the subkey memory, then writes
// K0..K25 one per cycle through the memory write port.
module rectangle128_keysched_ctrl
    import rectangle128_pkg::*;
(
    input  logic         Clk,
    input  logic         flush,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         skey_clr_n,
    output logic         skey_we,
    output logic [4:0]   skey_waddr,
    output logic [63:0]  skey_wdata
);

    ks_state_t    state_q;
    logic [4:0]   cnt_q;
    logic [4:0]   rc_q;
    logic [127:0] key_q;
    logic [127:0] key_d;
    logic         busy_q;
    logic         done_q;
    logic         clr_n_q;

    rectangle128_ks_round u_round (
        .state_i (key_q),
        .rc_i    (rc_q),
        .state_o (key_d)
    );

    // Schedule FSM with its registered status outputs.
    always_ff @(posedge Clk or negedge flush) begin
        if (!flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            rc_q    <= RC_INIT;
            key_q   <= 128'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            clr_n_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_CLEAR;
                        key_q   <= key_in;
                        rc_q    <= RC_INIT;
                        cnt_q   <= 5'd0;
                        clr_n_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state_q <= ST_GEN;
                    clr_n_q <= 1'b1;
                end
                ST_GEN: begin
                    // The update after K25 is harmless; cnt saturates at the last index.
                    key_q <= key_d;
                    rc_q  <= rc_next(rc_q);
                    if (cnt_q == LAST_IDX) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    cnt_q   <= 5'd0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    clr_n_q <= 1'b1;
                end
            endcase
        end
    end

    // Write port decodes only from registers, so inputs never reach it combinationally.
    always_comb begin
        if (state_q == ST_GEN) begin
            skey_we    = 1'b1;
            skey_waddr = cnt_q;
            skey_wdata = skey_extract(key_q);
        end else begin
            skey_we    = 1'b0;
            skey_waddr = 5'd0;
            skey_wdata = 64'd0;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign skey_clr_n = clr_n_q;

endmodule

// File: tb/tb_rectangle128_keysched_ctrl.sv
// Self-checking bench for rectangle128_keysched_ctrl with a behavioural subkey
// memory and a row/bit-level reference model of the key schedule.
module tb_rectangle128_keysched_ctrl;

    logic         Clk   = 1'b0;
    logic         flush = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = 128'd0;
    logic         busy;
    logic         done;
    logic         skey_clr_n;
    logic         skey_we;
    logic [4:0]   skey_waddr;
    logic [63:0]  skey_wdata;

    int n_checks = 0;
    int n_fail   = 0;
    int clr_pulses = 0;

    logic [63:0] mem [32];
    logic        mem_ready = 1'b0;
    logic [63:0] exp_k [26];

    int SB [16] = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [63:0]  exp;
    } vec_t;
    vec_t tbl [5];

    always #5 Clk = ~Clk;

    rectangle128_keysched_ctrl dut (
        .Clk        (Clk),
        .flush      (flush),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .skey_clr_n (skey_clr_n),
        .skey_we    (skey_we),
        .skey_waddr (skey_waddr),
        .skey_wdata (skey_wdata)
    );

    // Subkey memory: async clear, write port, ready once the last subkey lands.
    always @(posedge Clk or negedge skey_clr_n) begin
        if (!skey_clr_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= 64'd0;
            mem_ready <= 1'b0;
        end else if (skey_we) begin
            mem[skey_waddr] <= skey_wdata;
            if (skey_waddr == 5'd25) mem_ready <= 1'b1;
        end
    end

    always @(negedge Clk) begin
        if (skey_clr_n === 1'b0) clr_pulses <= clr_pulses + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return 128'({busy, done, skey_clr_n, skey_we, skey_waddr, skey_wdata});
    endfunction

    function automatic logic [127:0] mk(input logic b, input logic d, input logic c,
                                        input logic w, input logic [4:0] a, input logic [63:0] x);
        return 128'({b, d, c, w, a, x});
    endfunction

    // Reference schedule computed row by row from the algorithm description.
    task automatic model_fill(input logic [127:0] k);
        logic [31:0] r [4];
        logic [31:0] nr [4];
        logic [3:0]  s;
        int unsigned nib;
        int unsigned rc;
        for (int i = 0; i < 4; i++) r[i] = k[32*i +: 32];
        rc = 1;
        for (int t = 0; t < 26; t++) begin
            exp_k[t] = {r[3][15:0], r[2][15:0], r[1][15:0], r[0][15:0]};
            for (int j = 0; j < 8; j++) begin
                nib = 0;
                for (int i = 0; i < 4; i++) nib = nib + (32'(r[i][j]) << i);
                s = 4'(SB[nib]);
                for (int i = 0; i < 4; i++) r[i][j] = s[i];
            end
            nr[0] = ((r[0] << 8) | (r[0] >> 24)) ^ r[1] ^ 32'(rc);
            nr[1] = r[2];
            nr[2] = ((r[2] << 16) | (r[2] >> 16)) ^ r[3];
            nr[3] = r[0];
            for (int i = 0; i < 4; i++) r[i] = nr[i];
            rc = ((rc << 1) & 31) | (((rc >> 4) ^ (rc >> 2)) & 1);
        end
    endtask

    logic [63:0] cap [32];

    // One schedule from the accept edge E0; cycle n is the period after edge E(n-1).
    task automatic run_sched(input logic [127:0] k, input bit hold, input bit glitch, input int abort_at);
        int  pulses0;
        bit  gl;
        model_fill(k);
        for (int i = 0; i < 32; i++) cap[i] = 64'd0;
        pulses0 = clr_pulses;
        start  = 1'b1;
        key_in = k;
        @(posedge Clk);
        for (int n = 1; n <= 29; n++) begin
            @(negedge Clk);
            if (n == 1)
                chk($sformatf("cyc%0d clear", n), outs(), mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0));
            else if (n <= 27)
                chk($sformatf("cyc%0d write", n), outs(), mk(1'b1, 1'b0, 1'b1, 1'b1, 5'(n - 2), exp_k[n - 2]));
            else if (n == 28)
                chk($sformatf("cyc%0d done", n), outs(), mk(1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0));
            else
                chk($sformatf("cyc%0d idle", n), outs(), mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0));
            if (skey_we) cap[skey_waddr] = skey_wdata;
            if (n == 1)  chk("ready_after_clear", 128'(mem_ready), 128'(1'b0));
            if (n == 27) chk("ready_before_k25", 128'(mem_ready), 128'(1'b0));
            if (n == 28) chk("ready_after_k25", 128'(mem_ready), 128'(1'b1));
            if (n == 29) begin
                chk("clr_pulse_count", 128'(clr_pulses - pulses0), 128'(1));
                for (int i = 0; i < 26; i++)
                    chk($sformatf("mem[%0d]", i), 128'(mem[i]), 128'(exp_k[i]));
            end
            if (n == abort_at) begin
                flush = 1'b0;
                start = 1'b0;
                #1;
                chk("flush_async", outs(), mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0));
                @(posedge Clk);
                #1;
                chk("flush_hold", outs(), mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0));
                @(negedge Clk);
                flush = 1'b1;
                chk("flush_ready_low", 128'(mem_ready), 128'(1'b0));
                chk("flush_keeps_k9", 128'(mem[9]), 128'(exp_k[9]));
                chk("flush_no_k10", 128'(mem[10]), 128'(64'd0));
                return;
            end
            gl     = glitch && (n == 1 || n == 10 || n == 28);
            start  = hold || gl;
            key_in = gl ? ~k : {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    initial begin
        tbl[0] = '{128'd0, 0, 64'h0};
        tbl[1] = '{128'd0, 1, 64'h0000_0000_00FF_00FE};
        tbl[2] = '{{128{1'b1}}, 0, 64'hFFFF_FFFF_FFFF_FFFF};
        tbl[3] = '{{128{1'b1}}, 1, 64'hFF00_00FF_FF00_FF01};
        tbl[4] = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 0, 64'h4567_CDEF_BA98_3210};

        #2 flush = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset_outs", outs(), mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0));
        flush = 1'b1;
        @(negedge Clk);
        chk("idle_after_reset", outs(), mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0));

        for (int t = 0; t < 5; t++) begin
            run_sched(tbl[t].key, 1'b0, 1'b0, 0);
            start = 1'b0;
            @(negedge Clk);
            chk($sformatf("tbl%0d K%0d", t, tbl[t].idx), 128'(cap[tbl[t].idx]), 128'(tbl[t].exp));
        end

        for (int t = 0; t < 50; t++) begin
            run_sched({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0, 0);
            start = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        run_sched(128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, 1'b0, 1'b1, 0);
        start = 1'b0;
        @(negedge Clk);
        chk("no_restart_idle", outs(), mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0));

        run_sched(128'hDEAD_BEEF_0BAD_F00D_CAFE_BABE_1234_5678, 1'b0, 1'b0, 12);
        start = 1'b0;
        @(negedge Clk);
        run_sched(128'h1357_9BDF_2468_ACE0_FFFF_0000_AAAA_5555, 1'b0, 1'b0, 0);
        start = 1'b0;
        @(negedge Clk);

        run_sched({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b0, 0);
        run_sched({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b0, 0);
        start = 1'b0;
        repeat (2) @(negedge Clk);
        chk("final_idle", outs(), mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rectangle128_keysched_ctrl.md
# rectangle128_keysched_ctrl

Sequencer for the RECTANGLE-128 key schedule. On `start` it captures a 128-bit master key and clears the subkey memory. It then runs 25 key-update rounds and writes subkeys K0..K25, one per cycle, into `RECTANGLE128_skeymem` through that block's write port. It sits between the host/key-load path and the subkey memory; the cipher core reads only the memory.

## Interface
Parameters: none. All constants are in the package.

- `Clk` in 1: single clock.
- `flush` in 1: asynchronous, active-low reset.
- `start` in 1: request a new key schedule. Sampled only in IDLE.
- `key_in` in 128: master key, captured on the accepted `start` edge.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse after K25 is written.
- `skey_clr_n` out 1: registered, active-low clear to the memory's `flush`. Low for exactly one cycle.
- `skey_we` out 1: memory `WE`.
- `skey_waddr` out 5: memory `WAddr`.
- `skey_wdata` out 64: memory `KeyIn`.

## Operation
- Key state holds 4 rows of 32 bits: Row_i = key[32i+31:32i].
- Subkey extraction: {Row3[15:0], Row2[15:0], Row1[15:0], Row0[15:0]}.
- Round update, combinational:
  - S-box on columns j=0..7. Column nibble = {Row3[j], Row2[j], Row1[j], Row0[j]}, Row0 is the LSB.
  - S-box = 6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2.
  - Then Row0' = (Row0 <<< 8) ^ Row1, Row1' = Row2, Row2' = (Row2 <<< 16) ^ Row3, Row3' = Row0.
  - Then Row0'[4:0] ^= rc.
- Round constant `rc` is a 5-bit LFSR.
  - Initialised to 5'h01 on start.
  - Next value = {rc[3:0], rc[4]^rc[2]}.
  - Sequence: 01, 02, 04, 09, 12, 05, …
- FSM states: IDLE, CLEAR, GEN, DONE.
  - IDLE: when `start` = 1 → CLEAR. Load key state from `key_in`, set rc = 01, cnt = 0, `skey_clr_n` ← 0.
  - CLEAR: → GEN, `skey_clr_n` ← 1.
  - GEN: `skey_we` = 1, `skey_waddr` = cnt, `skey_wdata` = extract(state). On each edge: cnt += 1, state ← round(state, rc), rc ← next.
  - GEN exit: when cnt = 25 → DONE. The final state update is don't-care.
  - DONE: `done` = 1 for one cycle → IDLE.
- `skey_we`, `skey_waddr` and `skey_wdata` decode directly from the state, cnt and key registers. No combinational path from inputs.
- Outside GEN: `skey_we` = 0, `skey_waddr` = 0, `skey_wdata` = 0.
- `start` while busy is ignored, with no queueing. `key_in` changes while busy have no effect.
- `start` asserted in the DONE cycle is ignored. A new request is accepted only in IDLE.
- cnt is 5 bits and never exceeds 25. Addresses 26..31 are never driven.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `skey_clr_n` 1, `skey_we` 0, `skey_waddr` 0, `skey_wdata` 0, cnt 0, rc 01, key state 0.
- Cycle sequence, from the accepting edge E0:
  - E0: start accepted.
  - Cycle after E0: `skey_clr_n` = 0, which clears the memory and its `skey_ready`.
  - E2..E27: writes of addresses 0..25.
  - Cycle after E27: `done` = 1. The memory's `skey_ready` also rises after E27.
  - Cycle after E28: back in IDLE. `start` is accepted from E29.
- Latency from start to `done` is 28 cycles. Throughput is one schedule per 29 cycles.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.
  - The memory keeps any partial contents.
  - `skey_ready` stays 0 because CLEAR already ran and address 25 was never written.

## Structure
- Package `rectangle128_pkg` holds:
  - `NUM_SKEYS` = 26, `RC_INIT` = 5'h01, the 16-entry `SBOX` constant array.
  - The FSM state enum `ks_state_t`.
  - The function `skey_extract`.
- Sub-module `rectangle128_ks_round`: purely combinational round update, (128-bit state, 5-bit rc) → 128-bit state. It is reused by any future unrolled schedule.

## Test plan
- All-zero key, then start:
  - Writes at addresses 0..25 on consecutive cycles E2..E27.
  - K0 = 64'h0, K1 = 64'h0000_0000_00FF_00FE.
  - `done` high in the cycle after E27 only. `busy` high from the cycle after E0 through the `done` cycle.
- Random keys ×50: every write is compared against the team C golden model. The rc sequence observed starts 01, 02, 04, 09, 12, 05.
- `start` pulsed at the CLEAR cycle, in mid-GEN and in the DONE cycle with a different `key_in`: no restart, and subkeys match the first key. The next start is accepted only once back in IDLE.
- `flush` asserted at the write of address 10:
  - All outputs return to reset values asynchronously.
  - A following start produces a correct full schedule and `skey_ready` rises.
- Back-to-back schedules with start held high: a second schedule begins at E29. `skey_clr_n` pulses once per schedule. The memory `skey_ready` drops for the clear and reasserts after the second K25.
